// File: rtl/oc8051_gm_symrom_if.sv
// oc8051_gm_symrom_if
// Bundles the fetch port and the golden-model read ports of the symbolic ROM.
//   cxrom_req       fetch qualifier (master -> slave)
//   cxrom_addr      16-bit fetch base address (master -> slave)
//   cxrom_data_out  FETCH_N consecutive cells, byte k = cell(addr+k) (slave -> master)
//   rd_en           per read port access qualifier (master -> slave)
//   rd_addr         packed 16-bit per-port addresses (master -> slave)
//   rd_data         packed per-port read data (slave -> master)
interface oc8051_gm_symrom_if #(
  parameter int DATA_W   = 8,
  parameter int FETCH_N  = 4,
  parameter int RD_PORTS = 3
);
  logic                         cxrom_req;
  logic [15:0]                  cxrom_addr;
  logic [FETCH_N*DATA_W-1:0]    cxrom_data_out;
  logic [RD_PORTS-1:0]          rd_en;
  logic [RD_PORTS*16-1:0]       rd_addr;
  logic [RD_PORTS*DATA_W-1:0]   rd_data;

  modport master (
    output cxrom_req, cxrom_addr, rd_en, rd_addr,
    input  cxrom_data_out, rd_data
  );

  modport slave (
    input  cxrom_req, cxrom_addr, rd_en, rd_addr,
    output cxrom_data_out, rd_data
  );
endinterface

// File: rtl/oc8051_gm_symrom.sv
// oc8051_gm_symrom
// Symbolic ROM for golden-model checking. Each cell presents the free symbolic
// value word_in until it is first accessed (LAZY=1) or until the first edge
// after reset (LAZY=0); from then on it holds the value it showed at capture.
// Ports:
//   clk         single clock, all state on posedge
//   rst         asynchronous active-low reset
//   word_in     symbolic contents, cell i = word_in[i*DATA_W +: DATA_W]
//   bus         oc8051_gm_symrom_if slave: fetch port and RD_PORTS read ports
//   freeze_all  freeze every unfrozen cell at the next edge
//   frozen_cnt  registered count of frozen cells
//   all_frozen  high when every cell is frozen
//   oob_err     sticky out-of-range access flag
// Optional feature: define OC8051_GM_SYMROM_OOB_CHECK_EN to build the
// out-of-range checker; otherwise oob_err is constant 0.
module oc8051_gm_symrom #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8,
  parameter int FETCH_N    = 4,
  parameter int RD_PORTS   = 3,
  parameter int LAZY       = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [(1<<DEPTH_LOG2)*DATA_W-1:0]    word_in,
  oc8051_gm_symrom_if.slave                    bus,
  input  logic                                 freeze_all,
  output logic [DEPTH_LOG2:0]                  frozen_cnt,
  output logic                                 all_frozen,
  output logic                                 oob_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [DEPTH-1:0]  access;
  logic [DEPTH-1:0]  capture;
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [DATA_W-1:0] cell_val [DEPTH];
  logic [CNT_W-1:0]  cnt_d;
  logic              freeze_every;

  // Cell index wraps modulo DEPTH; the full address feeds the sum so the
  // truncation performs the wrap of a fetch window past the last cell.
  function automatic logic [DEPTH_LOG2-1:0] cell_idx(input logic [15:0] addr,
                                                     input int off);
    return DEPTH_LOG2'(32'(addr) + 32'(off));
  endfunction

  // Unfrozen cells pass the symbolic input straight through.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cell_val[i] = valid_q[i] ? data_q[i] : word_in[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    bus.cxrom_data_out = '0;
    for (int k = 0; k < FETCH_N; k++) begin
      bus.cxrom_data_out[k*DATA_W +: DATA_W] = cell_val[cell_idx(bus.cxrom_addr, k)];
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      bus.rd_data[p*DATA_W +: DATA_W] = cell_val[cell_idx(bus.rd_addr[p*16 +: 16], 0)];
    end
  end

  // Accesses are collected as a set, so overlapping fetch/read hits on one
  // cell still produce a single capture.
  always_comb begin
    access = '0;
    if (bus.cxrom_req) begin
      for (int k = 0; k < FETCH_N; k++) begin
        access[cell_idx(bus.cxrom_addr, k)] = 1'b1;
      end
    end
    for (int p = 0; p < RD_PORTS; p++) begin
      if (bus.rd_en[p]) begin
        access[cell_idx(bus.rd_addr[p*16 +: 16], 0)] = 1'b1;
      end
    end
  end

  // In eager mode every cell is requested at every edge; only the first edge
  // after reset actually captures because valid cells are masked out.
  assign freeze_every = freeze_all || (LAZY == 0);
  assign capture      = ~valid_q & (access | {DEPTH{freeze_every}});
  assign valid_d      = valid_q | capture;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + CNT_W'(valid_d[i]);
    end
    if (cnt_d > CNT_W'(DEPTH)) begin
      cnt_d = CNT_W'(DEPTH);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      frozen_cnt <= '0;
    end else begin
      valid_q    <= valid_d;
      frozen_cnt <= cnt_d;
    end
  end

  // Data registers carry no reset; a cleared valid bit hides their content.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (capture[i]) begin
        data_q[i] <= word_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign all_frozen = (frozen_cnt == CNT_W'(DEPTH));

`ifdef OC8051_GM_SYMROM_OOB_CHECK_EN
  logic oob_hit;
  logic oob_q;

  // Only the base address of a fetch is range checked, not the wrapped window.
  always_comb begin
    oob_hit = bus.cxrom_req && ((bus.cxrom_addr >> DEPTH_LOG2) != 16'd0);
    for (int p = 0; p < RD_PORTS; p++) begin
      if (bus.rd_en[p] && ((bus.rd_addr[p*16 +: 16] >> DEPTH_LOG2) != 16'd0)) begin
        oob_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oob_q <= 1'b0;
    end else begin
      oob_q <= oob_q | oob_hit;
    end
  end

  assign oob_err = oob_q;
`else
  assign oob_err = 1'b0;
`endif

endmodule
